// File: rtl/sc_spi_slave_engine_if.sv
// Word-level TX/RX handshake between the SPI target engine
// and its register block.
interface sc_spi_slave_engine_if;
  logic [31:0] TXDATA;
  logic        TXVALID;
  logic        TXREADY;
  logic [31:0] RXDATA;
  logic        RXVALID;

  modport master (
    output TXDATA, TXVALID,
    input  TXREADY, RXDATA, RXVALID
  );

  modport slave (
    input  TXDATA, TXVALID,
    output TXREADY, RXDATA, RXVALID
  );
endinterface

// File: rtl/sc_spi_slave_engine.sv
// SPI target engine: oversamples CSB/SCLK/MOSI in SYSCLK,
// drives MISO, exchanges words over a valid/ready bundle.
module sc_spi_slave_engine #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] IDLE_TX     = 32'hFFFF_FFFF
) (
  input  logic                 SYSCLK,
  input  logic                 SYSRSTB,
  input  logic                 CPOL,
  input  logic                 CPHA,
  input  logic                 BORDER,
  input  logic [4:0]           DWIDTH,
  sc_spi_slave_engine_if.slave bus,
  output logic                 TXUNDERRUN,
  output logic                 ABORT,
  output logic                 SPIBUSY,
  input  logic                 CSB,
  input  logic                 SCLK,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic                 MISO_OE
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_n;

  logic [SYNC_STAGES:0] csb_q, sclk_q, mosi_q;
  logic        csb_s, csb_fall, mosi_s;
  logic        sclk_rise, sclk_fall, lead, trail;
  logic        cpol_l, cpha_l, border_l;
  logic [4:0]  dw_l;
  logic        hold_full;
  logic [31:0] hold, tx_word, sr, rx, rx_n, rxdata;
  logic [5:0]  cnt;
  logic        rxvalid;
  logic        samp, adv, last, wend, take, abort_c;

  function automatic logic [31:0] step(
    input logic [31:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic pick(
    input logic [31:0] v, input logic lsb,
    input logic [4:0] dw);
    return lsb ? v[0] : v[dw];
  endfunction

  // CSB chain resets low so a CSB already low at reset
  // release does not look like a fresh selection.
  always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      csb_q  <= '0;
      sclk_q <= '0;
      mosi_q <= '0;
    end else begin
      csb_q  <= {csb_q[SYNC_STAGES-1:0], CSB};
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], SCLK};
      mosi_q <= {mosi_q[SYNC_STAGES-1:0], MOSI};
    end
  end

  assign csb_s     = csb_q[SYNC_STAGES-1];
  assign csb_fall  = ~csb_s & csb_q[SYNC_STAGES];
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign mosi_s    = mosi_q[SYNC_STAGES];

  assign lead  = cpol_l ? sclk_fall : sclk_rise;
  assign trail = cpol_l ? sclk_rise : sclk_fall;

  // With CPHA=0 the trailing edge that closes a word arrives
  // after the next LOAD (cnt==0) and must not advance MISO.
  assign samp = (state == SHIFT) & (cpha_l ? trail : lead);
  assign adv  = (state == SHIFT) &
                (cpha_l ? lead : (trail & (cnt != 6'd0)));
  assign last = (cnt == {1'b0, dw_l});
  assign wend = samp & last;

  assign tx_word = hold_full ? hold : IDLE_TX;
  assign rx_n    = border_l
                 ? ((rx >> 1) | ({31'd0, mosi_s} << dw_l))
                 : {rx[30:0], mosi_s};

  always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
    if (!SYSRSTB) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    abort_c = 1'b0;
    unique case (state)
      IDLE:  if (csb_fall) state_n = LOAD;
      LOAD:  begin
        if (csb_s) state_n = IDLE;
        else begin
          state_n = SHIFT;
          take    = 1'b1;
        end
      end
      SHIFT: begin
        if (csb_s) begin
          state_n = IDLE;
          abort_c = ~wend & (samp | (cnt != 6'd0));
        end else if (wend) begin
          state_n = LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      cpol_l     <= 1'b0;
      cpha_l     <= 1'b0;
      border_l   <= 1'b0;
      dw_l       <= '0;
      hold_full  <= 1'b0;
      hold       <= '0;
      sr         <= '0;
      rx         <= '0;
      cnt        <= '0;
      rxdata     <= '0;
      rxvalid    <= 1'b0;
      TXUNDERRUN <= 1'b0;
      ABORT      <= 1'b0;
      MISO       <= 1'b0;
    end else begin
      rxvalid    <= 1'b0;
      TXUNDERRUN <= 1'b0;
      ABORT      <= abort_c;
      if (state == IDLE && csb_fall) begin
        cpol_l   <= CPOL;
        cpha_l   <= CPHA;
        border_l <= BORDER;
        dw_l     <= DWIDTH;
      end
      if (take && hold_full) begin
        hold_full <= 1'b0;
      end else if (bus.TXVALID && !hold_full) begin
        hold      <= bus.TXDATA;
        hold_full <= 1'b1;
      end
      if (state == IDLE) MISO <= 1'b0;
      if (take) begin
        TXUNDERRUN <= ~hold_full;
        sr   <= cpha_l ? tx_word : step(tx_word, border_l);
        MISO <= pick(tx_word, border_l, dw_l);
        rx   <= '0;
        cnt  <= '0;
      end
      if (adv) begin
        MISO <= pick(sr, border_l, dw_l);
        sr   <= step(sr, border_l);
      end
      if (samp) begin
        rx  <= rx_n;
        cnt <= cnt + 6'd1;
        if (last) begin
          rxdata  <= rx_n;
          rxvalid <= 1'b1;
        end
      end
    end
  end

  assign bus.TXREADY = ~hold_full;
  assign bus.RXDATA  = rxdata;
  assign bus.RXVALID = rxvalid;
  assign SPIBUSY     = (state != IDLE);
  assign MISO_OE     = (state != IDLE);

endmodule

// File: doc/sc_spi_slave_engine.md
Name: sc_spi_slave_engine

Overview:
SPI target-side protocol engine, the responder counterpart of the SPI master engine. It oversamples an external master's CSB/SCLK/MOSI in the SYSCLK domain and drives MISO. Word-level TX/RX data is exchanged with a register block through valid/ready handshakes. Modes 0-3, 1-32 bit words, MSB- or LSB-first, continuous multi-word transfers within one CSB assertion.

Parameters:
SYNC_STAGES, 2, synchronizer depth for CSB/SCLK/MOSI (legal 2-3)
IDLE_TX, 32'hFFFFFFFF, shift pattern used on TX underrun

Ports:
SYSCLK  input  1  system clock; must be at least 8x SCLK frequency
SYSRSTB  input  1  reset, asynchronous, active-low
CPOL  input  1  SCLK idle level
CPHA  input  1  0: sample on leading edge; 1: sample on trailing edge
BORDER  input  1  0: MSB first; 1: LSB first
DWIDTH  input  5  word length minus 1 (0 -> 1 bit, 31 -> 32 bits)
TXDATA  input  32  next word to transmit, right-justified
TXVALID  input  1  TXDATA valid
TXREADY  output  1  TX holding register empty
RXDATA  output  32  last received word, right-justified, upper bits 0
RXVALID  output  1  one-cycle pulse, RXDATA updated
TXUNDERRUN  output  1  one-cycle pulse, word started with empty holding register
ABORT  output  1  one-cycle pulse, CSB deasserted mid-word
SPIBUSY  output  1  synchronized CSB asserted
CSB  input  1  chip select from master, active-low
SCLK  input  1  serial clock from master
MOSI  input  1  serial data in
MISO  output  1  serial data out
MISO_OE  output  1  MISO output enable (high while selected)

Behaviour:
- Reset values: TXREADY=1, RXDATA=0, RXVALID=0, TXUNDERRUN=0, ABORT=0, SPIBUSY=0, MISO=0, MISO_OE=0; state IDLE, bit counter 0, holding register empty.
- Sync: CSB, SCLK, MOSI each pass SYNC_STAGES flops plus one history flop; edges are detected on the synchronized signal. Leading edge = SCLK leaving CPOL level; trailing edge = SCLK returning to CPOL level.
- CPOL, CPHA, BORDER and DWIDTH are latched on the CSB-assert detection cycle. Changes while SPIBUSY=1 have no effect.
- TX holding register: loads when TXVALID&TXREADY, after which TXREADY=0. TXREADY returns to 1 in the cycle after the holding register moves to the shift register.
- States:
  - IDLE: MISO_OE=0. Synchronized CSB fall -> LOAD.
  - LOAD (1 cycle): SPIBUSY=1, MISO_OE=1. Shift register takes the holding register, or IDLE_TX plus a TXUNDERRUN pulse if empty. Bit counter cleared -> SHIFT.
  - SHIFT, CPHA=0: MISO presents the first bit from LOAD. Sample MOSI on leading edges; advance MISO on trailing edges, except after the last bit of a word.
  - SHIFT, CPHA=1: advance MISO on leading edges (first bit on first leading edge); sample on trailing edges.
  - Word end, after DWIDTH+1 samples: RXDATA updated and RXVALID pulses within 1 cycle of the last sample edge. Then -> LOAD (CSB still low) for the next word, with no gap bits.
- MISO changes within SYNC_STAGES+2 SYSCLK of the driving SCLK edge.
- Bit order: BORDER=0 sends TX bit DWIDTH first and fills RX from the LSB upward by shift-left. BORDER=1 sends bit 0 first and fills RX from bit DWIDTH downward.
- CSB rise in any state -> IDLE next cycle: SPIBUSY=0, MISO_OE=0.
  - If 0 < bit count < DWIDTH+1: ABORT pulses, partial RX word discarded (RXDATA unchanged, no RXVALID), and the TX word in flight is lost.
  - A holding register already loaded is kept for the next selection.
- Simultaneous: word end and CSB rise in the same cycle -> RXVALID pulses, no ABORT.
- TXVALID in the same cycle as LOAD with an empty register: the word is not used (underrun) and is captured for the next word.
- SCLK edges while in IDLE are ignored.
- Async reset mid-transfer clears everything immediately. The engine resynchronizes at the next CSB fall.

Test Plan:
- Mode 0, DWIDTH=7, BORDER=0, TXDATA=0xA5 preloaded, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; RXDATA=0x0000003C, one RXVALID pulse, TXREADY back to 1.
- Mode 3, DWIDTH=31, BORDER=1, TXDATA=0x12345678, master sends 0xDEADBEEF LSB-first -> RXDATA=0xDEADBEEF; MISO bit0 first.
- Modes 1 and 2, DWIDTH=15, three back-to-back words in one CSB assertion with TX refilled on TXREADY -> three RXVALID pulses, no underrun, words in order.
- Empty holding register at CSB fall, DWIDTH=7 -> TXUNDERRUN pulse, MISO all ones; TXVALID arriving mid-word is used for word 2.
- CSB rises after 5 bits -> ABORT pulse, no RXVALID, RXDATA unchanged, MISO_OE=0 within SYNC_STAGES+2 cycles. Also change DWIDTH mid-transfer -> latched value used.
- Assert SYSRSTB=0 mid-word -> all outputs at reset values asynchronously. Next full mode-0 transfer completes correctly.
